// File: rtl/pipelined_bls_subtractor_if.sv
// Operand/result handshake bundle for pipelined_bls_subtractor.
// The slave modport is the subtractor's view. The master modport is the
// view of the block that supplies operands and consumes results.
interface pipelined_bls_subtractor_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic             Bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Diff;
    logic             Bout;
    logic             Ovf;
    logic             Zero;

    modport slave (
        input  in_valid, X, Y, Bin, out_ready,
        output in_ready, out_valid, Diff, Bout, Ovf, Zero
    );

    modport master (
        output in_valid, X, Y, Bin, out_ready,
        input  in_ready, out_valid, Diff, Bout, Ovf, Zero
    );
endinterface

// File: rtl/pipelined_bls_subtractor.sv
// Pipelined borrow-lookahead subtractor: Diff = X - Y - Bin.
// Each stage resolves one 4-bit group, so there are WIDTH/4 stages.
// One global advance signal moves or stalls the whole pipeline.
module pipelined_bls_subtractor #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    pipelined_bls_subtractor_if.slave   bus
);
    localparam int unsigned NGRP = WIDTH / 4;

    // Resolves one 4-bit group. All four borrows are computed directly
    // from generate/propagate, with no ripple between them.
    // Result is {group borrow-out, 4 difference bits}.
    function automatic logic [4:0] f_group_sub(
        input logic [3:0] x,
        input logic [3:0] y,
        input logic       bin
    );
        logic [3:0] g;
        logic [3:0] p;
        logic [3:0] b;
        logic [3:0] d;
        g    = ~x & y;
        p    = ~(x ^ y);
        b[0] = g[0] | (p[0] & bin);
        b[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
        b[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & bin);
        b[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & bin);
        d    = ~p ^ {b[2:0], bin};
        return {b[3], d};
    endfunction

    // Stage registers: valid bit, operands carried forward, completed
    // difference bits, and the group borrow-out.
    logic             r_v [NGRP];
    logic [WIDTH-1:0] r_x [NGRP];
    logic [WIDTH-1:0] r_y [NGRP];
    logic [WIDTH-1:0] r_d [NGRP];
    logic             r_b [NGRP];
    logic             r_ovf;
    logic             r_zero;

    // Value each stage register would load on the next advance.
    logic             w_v_nxt [NGRP];
    logic [WIDTH-1:0] w_x_nxt [NGRP];
    logic [WIDTH-1:0] w_y_nxt [NGRP];
    logic [WIDTH-1:0] w_d_nxt [NGRP];
    logic             w_b_nxt [NGRP];
    logic             w_ovf_nxt;
    logic             w_zero_nxt;
    logic             w_adv;

    assign w_adv = ~r_v[NGRP-1] | bus.out_ready;

    for (genvar k = 0; k < NGRP; k++) begin : g_stage
        localparam logic [WIDTH-1:0] GMASK = WIDTH'(4'hF) << (4 * k);

        logic             w_v_in;
        logic [WIDTH-1:0] w_x_in;
        logic [WIDTH-1:0] w_y_in;
        logic [WIDTH-1:0] w_d_in;
        logic             w_b_in;
        logic [4:0]       w_res;

        if (k == 0) begin : g_first
            assign w_v_in = bus.in_valid;
            assign w_x_in = bus.X;
            assign w_y_in = bus.Y;
            assign w_d_in = '0;
            assign w_b_in = bus.Bin;
        end else begin : g_next
            assign w_v_in = r_v[k-1];
            assign w_x_in = r_x[k-1];
            assign w_y_in = r_y[k-1];
            assign w_d_in = r_d[k-1];
            assign w_b_in = r_b[k-1];
        end

        assign w_res      = f_group_sub(w_x_in[4*k +: 4], w_y_in[4*k +: 4], w_b_in);
        assign w_v_nxt[k] = w_v_in;
        assign w_x_nxt[k] = w_x_in;
        assign w_y_nxt[k] = w_y_in;
        assign w_d_nxt[k] = (w_d_in & ~GMASK) | (WIDTH'(w_res[3:0]) << (4 * k));
        assign w_b_nxt[k] = w_res[4];
    end

    // The flags are computed alongside the last group so that they are
    // registered together with Diff.
    assign w_ovf_nxt  = (w_x_nxt[NGRP-1][WIDTH-1] ^ w_y_nxt[NGRP-1][WIDTH-1])
                      & (w_d_nxt[NGRP-1][WIDTH-1] ^ w_x_nxt[NGRP-1][WIDTH-1]);
    assign w_zero_nxt = ~|w_d_nxt[NGRP-1];

    // All stages move together on an advance and hold otherwise.
    // An empty upstream stage loads a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < NGRP; k++) begin
                r_v[k] <= 1'b0;
                r_x[k] <= '0;
                r_y[k] <= '0;
                r_d[k] <= '0;
                r_b[k] <= 1'b0;
            end
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_adv) begin
            for (int unsigned k = 0; k < NGRP; k++) begin
                r_v[k] <= w_v_nxt[k];
                r_x[k] <= w_x_nxt[k];
                r_y[k] <= w_y_nxt[k];
                r_d[k] <= w_d_nxt[k];
                r_b[k] <= w_b_nxt[k];
            end
            r_ovf  <= w_ovf_nxt;
            r_zero <= w_zero_nxt;
        end
    end

    assign bus.in_ready  = w_adv;
    assign bus.out_valid = r_v[NGRP-1];
    assign bus.Diff      = r_d[NGRP-1];
    assign bus.Bout      = r_b[NGRP-1];
    assign bus.Ovf       = r_ovf;
    assign bus.Zero      = r_zero;
endmodule
